pipe_hazard_ctl: RTL and testbench

//  Sequences the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM): load-use bubble insertion,

---
 rtl/pipe_hazard_ctl.sv | 129 ++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard sequencer: load-use bubbles, taken-branch flush, memory-wait stall and timeout.
// Control outputs are combinational. mem_timeout and stall_count are registered.
module pipe_hazard_ctl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             exmem_hold,
  output logic             dmem_req,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              timeout_d;
  logic              memop, taken, luse;
  logic              pc_wr_c, ifid_wr_c, ifid_fl_c, idex_fl_c, exmem_fl_c, hold_c, req_c;

  assign memop = exmem_memread | exmem_memwrite;
  assign taken = exmem_branch & exmem_zero;
  assign luse  = idex_memread & (idex_rt != 5'd0) &
                 ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  always_comb begin
    pc_wr_c    = 1'b1;
    ifid_wr_c  = 1'b1;
    ifid_fl_c  = 1'b0;
    idex_fl_c  = 1'b0;
    exmem_fl_c = 1'b0;
    hold_c     = 1'b0;
    req_c      = 1'b0;
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    timeout_d  = mem_timeout;
    case (state_q)
      RUN: begin
        if (memop && !dmem_ready) begin
          req_c     = 1'b1;
          hold_c    = 1'b1;
          pc_wr_c   = 1'b0;
          ifid_wr_c = 1'b0;
          state_d   = MEM_WAIT;
          wcnt_d    = '0;
        end else if (memop) begin
          req_c = 1'b1;
        end else if (taken) begin
          ifid_fl_c  = 1'b1;
          idex_fl_c  = 1'b1;
          exmem_fl_c = 1'b1;
        end else if (luse) begin
          pc_wr_c   = 1'b0;
          ifid_wr_c = 1'b0;
          idex_fl_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Request stays up through the release cycle so the access completes.
        req_c = 1'b1;
        if (dmem_ready) begin
          state_d = RUN;
        end else begin
          hold_c    = 1'b1;
          pc_wr_c   = 1'b0;
          ifid_wr_c = 1'b0;
          if (wcnt_q == WCNT_LAST) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ERROR: begin
        pc_wr_c   = 1'b0;
        ifid_wr_c = 1'b0;
        hold_c    = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Reset forces every control output low regardless of state.
  always_comb begin
    pc_write    = reset & pc_wr_c;
    ifid_write  = reset & ifid_wr_c;
    ifid_flush  = reset & ifid_fl_c;
    idex_flush  = reset & idex_fl_c;
    exmem_flush = reset & exmem_fl_c;
    exmem_hold  = reset & hold_c;
    dmem_req    = reset & req_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_timeout <= timeout_d;
      if (!pc_wr_c && (state_q != ERROR) && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl with a cycle-level reference model and literal spot checks.
module tb_pipe_hazard_ctl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             idex_memread, exmem_branch, exmem_zero, exmem_memread, exmem_memwrite, dmem_ready;
  logic [4:0]       idex_rt, ifid_rs, ifid_rt;
  logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, exmem_hold, dmem_req;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  int vectors    = 0;
  int miscompares = 0;

  pipe_hazard_ctl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .exmem_hold(exmem_hold),
    .dmem_req(dmem_req), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = running, 1 = waiting on memory, 2 = timed out.
  int  m_mode  = 0;
  int  m_waits = 0;
  bit  m_to    = 0;
  int  m_cnt   = 0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  function automatic logic [7:0] model_outs();
    bit memop, taken, luse, run_stall, bubble, stall, flush_all, hold, req;
    if (reset !== 1'b1) return 8'h00;
    memop     = exmem_memread || exmem_memwrite;
    taken     = exmem_branch && exmem_zero;
    luse      = idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    run_stall = (m_mode == 0) && memop && !dmem_ready;
    bubble    = (m_mode == 0) && !memop && !taken && luse;
    hold      = run_stall || (m_mode == 1 && !dmem_ready) || m_mode == 2;
    stall     = hold || bubble;
    flush_all = (m_mode == 0) && !memop && taken;
    req       = ((m_mode == 0) && memop) || m_mode == 1;
    return {!stall, !stall, flush_all, flush_all || bubble, flush_all, hold, req, m_to};
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [7:0] o;
    if (!reset) begin
      m_mode = 0; m_waits = 0; m_to = 0; m_cnt = 0;
    end else begin
      o = model_outs();
      if (!o[7] && m_mode != 2 && m_cnt < CNT_MAX) m_cnt++;
      if (m_mode == 0) begin
        if ((exmem_memread || exmem_memwrite) && !dmem_ready) begin
          m_mode = 1; m_waits = 0;
        end
      end else if (m_mode == 1) begin
        if (dmem_ready) m_mode = 0;
        else begin
          m_waits++;
          if (m_waits == TIMEOUT) begin m_mode = 2; m_to = 1; end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_outs();
    return {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, exmem_hold, dmem_req, mem_timeout};
  endfunction

  always @(negedge clk) begin
    check("model_outs", {24'd0, dut_outs()}, {24'd0, model_outs()});
    check("model_count", {16'd0, stall_count}, (reset === 1'b1) ? m_cnt : 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    exmem_branch = 0; exmem_zero = 0; exmem_memread = 0; exmem_memwrite = 0; dmem_ready = 1;
  endtask

  initial begin
    idle();
    reset = 0;
    #2;
    check("reset_outs", {24'd0, dut_outs()}, 32'h00);
    check("reset_count", {16'd0, stall_count}, 32'd0);
    tick(); tick();
    reset = 1;
    tick();
    #1;
    check("idle_outs", {24'd0, dut_outs()}, 32'hC0);

    // T1: load-use on rs
    idex_memread = 1; idex_rt = 5; ifid_rs = 5; ifid_rt = 7;
    #1 check("t1_bubble", {24'd0, dut_outs()}, 32'h10);
    tick();
    idle();
    check("t1_count", {16'd0, stall_count}, 32'd1);
    #1 check("t1_after", {24'd0, dut_outs()}, 32'hC0);

    // T2: load to r0 never creates a hazard
    idex_memread = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    #1 check("t2_no_bubble", {24'd0, dut_outs()}, 32'hC0);
    tick();
    check("t2_count", {16'd0, stall_count}, 32'd1);

    // T3: taken branch overrides load-use
    idex_memread = 1; idex_rt = 9; ifid_rs = 3; ifid_rt = 9;
    exmem_branch = 1; exmem_zero = 1;
    #1 check("t3_flush", {24'd0, dut_outs()}, 32'hF8);
    tick();
    idle();
    check("t3_count", {16'd0, stall_count}, 32'd1);

    // Zero-wait store: request with no stall
    exmem_memwrite = 1; dmem_ready = 1;
    #1 check("zero_wait", {24'd0, dut_outs()}, 32'hC2);
    tick();

    // T4: store, three not-ready cycles then release
    exmem_memwrite = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("t4_stall", {24'd0, dut_outs()}, 32'h06);
      tick();
    end
    dmem_ready = 1;
    #1 check("t4_release", {24'd0, dut_outs()}, 32'hC2);
    tick();
    idle();
    check("t4_count", {16'd0, stall_count}, 32'd4);

    // Hazards during MEM_WAIT are ignored, then resolved after release
    exmem_memread = 1; dmem_ready = 0;
    tick();
    dmem_ready = 1; exmem_branch = 1; exmem_zero = 1;
    idex_memread = 1; idex_rt = 4; ifid_rs = 4;
    #1 check("wait_ignore", {24'd0, dut_outs()}, 32'hC2);
    tick();
    exmem_memread = 0;
    #1 check("post_release_flush", {24'd0, dut_outs()}, 32'hF8);
    tick();
    idle();
    check("wait_count", {16'd0, stall_count}, 32'd5);

    // T5: memory never ready -> timeout
    exmem_memread = 1; dmem_ready = 0;
    for (int i = 0; i < 1 + TIMEOUT + 3; i++) tick();
    check("t5_timeout", {31'd0, mem_timeout}, 32'd1);
    check("t5_error_outs", {24'd0, dut_outs()}, 32'h05);
    check("t5_count", {16'd0, stall_count}, 32'd22);
    idle();
    tick();
    check("t5_sticky", {31'd0, mem_timeout}, 32'd1);
    reset = 0;
    #1 check("t5_reset_to", {31'd0, mem_timeout}, 32'd0);
    tick();
    reset = 1;
    tick();

    // T6: reset pulsed mid-MEM_WAIT
    exmem_memwrite = 1; dmem_ready = 0;
    tick(); tick(); tick();
    #2 reset = 0;
    #1 check("t6_outs", {24'd0, dut_outs()}, 32'h00);
    check("t6_count", {16'd0, stall_count}, 32'd0);
    idle();
    tick();
    reset = 1;
    tick();
    #1 check("t6_run", {24'd0, dut_outs()}, 32'hC0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
